// File: rtl/snake_dir_decoder_if.sv
// Key-event / game-tick bus between keyboard driver, snake_dir_decoder and
// the snake game block. Signal names match the legacy port list.
interface snake_dir_decoder_if;
  logic       valid;
  logic       makeBreak;
  logic [7:0] outCode;
  logic       update;
  logic [1:0] direction;
  logic       pause;
  logic [2:0] qCount;
  logic       overflow;

  // Event source side (keyboard driver + tick logic), also used by benches.
  modport master (
    output valid, makeBreak, outCode, update,
    input  direction, pause, qCount, overflow
  );

  // Decoder side.
  modport slave (
    input  valid, makeBreak, outCode, update,
    output direction, pause, qCount, overflow
  );
endinterface

// File: rtl/snake_dir_decoder.sv
// snake_dir_decoder: turns PS/2 set-2 scan-code events into the 2-bit snake
// direction (00 up, 01 right, 10 down, 11 left). Handles the E0 prefix,
// ignores breaks, suppresses auto-repeat and 180-degree reversals, queues
// quick presses (QDEPTH entries, popped one per update tick) and toggles
// pause on space.
// Optional macro SNAKE_WASD_KEYS_EN: also decode W/A/S/D (1D/1C/1B/23).
module snake_dir_decoder #(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [1:0]  INIT_DIR = 2'b01
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  snake_dir_decoder_if.slave  bus
);

  localparam logic [7:0] C_E0    = 8'hE0;
  localparam logic [7:0] C_UP    = 8'h75;
  localparam logic [7:0] C_RIGHT = 8'h74;
  localparam logic [7:0] C_DOWN  = 8'h72;
  localparam logic [7:0] C_LEFT  = 8'h6B;
  localparam logic [7:0] C_SPACE = 8'h29;

  typedef enum logic {IDLE, EXT} state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_dir;
  logic        r_pause;
  logic [2:0]  r_cnt;
  logic        r_ovf;
  logic [1:0]  r_rd, r_wr;
  logic [1:0]  r_q [4];

  logic        w_key;
  logic [1:0]  w_cand;
  logic        w_space;
  logic [1:0]  w_newest_idx;
  logic [1:0]  w_ref;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_push_ok;

  function automatic logic [1:0] f_inc(input logic [1:0] p);
    return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Prefix state register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Prefix next-state plus key decode of the current event.
  always_comb begin
    w_state_nxt = r_state;
    w_key       = 1'b0;
    w_cand      = 2'b00;
    w_space     = 1'b0;
    if (bus.valid) begin
      if (bus.outCode == C_E0) begin
        w_state_nxt = EXT;
      end else if (r_state == EXT) begin
        w_state_nxt = IDLE;
        if (bus.makeBreak) begin
          case (bus.outCode)
            C_UP:    begin w_key = 1'b1; w_cand = 2'b00; end
            C_RIGHT: begin w_key = 1'b1; w_cand = 2'b01; end
            C_DOWN:  begin w_key = 1'b1; w_cand = 2'b10; end
            C_LEFT:  begin w_key = 1'b1; w_cand = 2'b11; end
            default: ;
          endcase
        end
      end else if (bus.makeBreak) begin
        case (bus.outCode)
          C_SPACE: w_space = 1'b1;
`ifdef SNAKE_WASD_KEYS_EN
          8'h1D:   begin w_key = 1'b1; w_cand = 2'b00; end
          8'h23:   begin w_key = 1'b1; w_cand = 2'b01; end
          8'h1B:   begin w_key = 1'b1; w_cand = 2'b10; end
          8'h1C:   begin w_key = 1'b1; w_cand = 2'b11; end
`else
`endif
          default: ;
        endcase
      end
    end
  end

  // Candidate filtering against the newest pending direction, push/pop decisions.
  always_comb begin
    w_newest_idx = (r_wr == 2'd0) ? 2'(QDEPTH - 1) : r_wr - 2'd1;
    w_ref        = (r_cnt != 3'd0) ? r_q[w_newest_idx] : r_dir;
    w_push       = w_key && (w_cand != w_ref) && (w_cand != (w_ref ^ 2'b10));
    w_pop        = bus.update && !r_pause && (r_cnt != 3'd0);
    w_full       = (r_cnt == 3'(QDEPTH));
    // A pop on the same edge frees the slot, so a full queue still accepts.
    w_push_ok    = w_push && (!w_full || w_pop);
  end

  // Direction, pause, overflow and queue bookkeeping.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_dir   <= INIT_DIR;
      r_pause <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_rd    <= '0;
      r_wr    <= '0;
    end else begin
      r_pause <= r_pause ^ w_space;
      r_ovf   <= w_push && !w_push_ok;
      r_cnt   <= r_cnt + {2'b00, w_push_ok} - {2'b00, w_pop};
      if (w_pop) begin
        r_dir <= r_q[r_rd];
        r_rd  <= f_inc(r_rd);
      end
      if (w_push_ok) r_wr <= f_inc(r_wr);
    end
  end

  // Queue storage; contents are don't-care after reset.
  always_ff @(posedge CLOCK_50) begin
    if (w_push_ok) r_q[r_wr] <= w_cand;
  end

  assign bus.direction = r_dir;
  assign bus.pause     = r_pause;
  assign bus.qCount    = r_cnt;
  assign bus.overflow  = r_ovf;

endmodule
